// File: rtl/fetch_decode.sv
// cpu15 front end: fetches a 15-bit word from program ROM at the exec stage's
// PC, decodes it and strobes the exec stage for exactly one cycle per instruction.
module fetch_decode #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ICNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUN,
  input  logic [7:0]        P_COUNT,
  output logic              ROM_REQ,
  output logic [7:0]        ROM_ADDR,
  input  logic              ROM_ACK,
  input  logic [14:0]       ROM_DATA,
  output logic [3:0]        OP_CODE,
  output logic [2:0]        REG_A_SEL,
  output logic [2:0]        REG_B_SEL,
  output logic [7:0]        OP_DATA,
  output logic              EX_EN,
  output logic              HALTED,
  output logic              FETCH_ERR,
  output logic [ICNT_W-1:0] INSTR_CNT
);

  localparam int unsigned   TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_SETTLE,
    S_HALT,
    S_ERR
  } state_t;

  state_t      state;
  logic [14:0] ir;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      ir        <= '0;
      to_cnt    <= '0;
      ROM_REQ   <= 1'b0;
      ROM_ADDR  <= '0;
      OP_CODE   <= '0;
      REG_A_SEL <= '0;
      REG_B_SEL <= '0;
      OP_DATA   <= '0;
      EX_EN     <= 1'b0;
      HALTED    <= 1'b0;
      FETCH_ERR <= 1'b0;
      INSTR_CNT <= '0;
    end else begin
      EX_EN <= 1'b0;
      case (state)
        S_IDLE: begin
          if (RUN) begin
            ROM_ADDR <= P_COUNT;
            ROM_REQ  <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (ROM_ACK) begin
            ir      <= ROM_DATA;
            to_cnt  <= '0;
            ROM_REQ <= 1'b0;
            state   <= S_DECODE;
          end else if (to_cnt == TO_LAST) begin
            to_cnt    <= '0;
            ROM_REQ   <= 1'b0;
            FETCH_ERR <= 1'b1;
            state     <= S_ERR;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_DECODE: begin
          // REG_B_SEL and OP_DATA deliberately share bits [7:5].
          OP_CODE   <= ir[14:11];
          REG_A_SEL <= ir[10:8];
          REG_B_SEL <= ir[7:5];
          OP_DATA   <= ir[7:0];
          EX_EN     <= 1'b1;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          INSTR_CNT <= INSTR_CNT + ICNT_W'(1);
          if (OP_CODE == 4'hF) begin
            HALTED <= 1'b1;
            state  <= S_HALT;
          end else begin
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (RUN) begin
            ROM_ADDR <= P_COUNT;
            ROM_REQ  <= 1'b1;
            state    <= S_FETCH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: state <= S_HALT;
        S_ERR:  state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Front end of the cpu15 core.
- Issues instruction fetches to program ROM at the address given by the exec stage's program counter, and latches the returned 15-bit word.
- Decodes the word into opcode, register selects and immediate, then strobes the exec stage for exactly one cycle per instruction.
- Sequences fetch/execute/settle, stops on HLT, and flags ROM timeouts.

Parameters:
- TIMEOUT, 16, max FETCH cycles without ROM_ACK before fetch error (>=2)
- ICNT_W, 16, width of retired-instruction counter

Ports:
- CLK  input  1  core clock
- RESET  input  1  synchronous reset, active-high
- RUN  input  1  level; allow instruction issue
- P_COUNT  input  8  program counter from exec stage
- ROM_REQ  output  1  fetch request, held until ack
- ROM_ADDR  output  8  fetch address, stable while ROM_REQ=1
- ROM_ACK  input  1  ROM word valid this cycle (sampled only while ROM_REQ=1)
- ROM_DATA  input  15  instruction word
- OP_CODE  output  4  INSTR[14:11]
- REG_A_SEL  output  3  INSTR[10:8]
- REG_B_SEL  output  3  INSTR[7:5]
- OP_DATA  output  8  INSTR[7:0]
- EX_EN  output  1  one-cycle exec enable
- HALTED  output  1  HLT retired
- FETCH_ERR  output  1  sticky ROM timeout flag
- INSTR_CNT  output  ICNT_W  retired instruction count

Behaviour:
- Clock and reset: all state is updated on posedge CLK.
- RESET=1 has priority, including mid-fetch. It drives:
  - state to IDLE;
  - all outputs to 0;
  - timeout counter to 0.
- States: IDLE, FETCH, DECODE, EXEC, SETTLE, HALT, ERR.
- IDLE:
  - RUN=1: latch ROM_ADDR<=P_COUNT, go to FETCH.
  - Otherwise stay.
- FETCH:
  - ROM_REQ=1; ROM_ADDR held constant.
  - ROM_ACK=1: capture ROM_DATA into the instruction register, clear the timeout counter, drop ROM_REQ next cycle, go to DECODE.
  - No ack: the counter increments.
  - Counter reaches TIMEOUT-1 with ROM_ACK=0: go to ERR.
  - Ack on that same cycle: ack wins, no error.
- DECODE:
  - OP_CODE, REG_A_SEL, REG_B_SEL, OP_DATA register from the instruction register and stay stable until the next DECODE.
  - REG_B_SEL and OP_DATA overlap on bits [7:5] by design.
  - Go to EXEC.
- EXEC:
  - EX_EN=1 for exactly this cycle.
  - INSTR_CNT increments, wrapping modulo 2^ICNT_W.
  - OP_CODE=4'hF: go to HALT. Otherwise go to SETTLE.
- SETTLE:
  - One idle cycle so the exec stage's P_COUNT and register writeback take effect.
  - RUN=1: latch ROM_ADDR<=P_COUNT, go to FETCH.
  - RUN=0: go to IDLE.
- HALT:
  - HALTED=1, EX_EN=0, ROM_REQ=0.
  - Exit only via RESET; RUN is ignored.
- ERR:
  - FETCH_ERR=1, ROM_REQ=0, EX_EN=0.
  - Exit only via RESET.
- Timing:
  - Minimum instruction period is 4 cycles (FETCH with immediate ack, DECODE, EXEC, SETTLE).
  - Each cycle of ack delay adds one.
- ROM_ACK outside FETCH is ignored.
- RUN dropping during FETCH/DECODE/EXEC does not abort: the current instruction completes and the block parks in IDLE after SETTLE.
- EX_EN is never asserted twice without an intervening FETCH.

Test Plan:
- Immediate-ack ROM, program at 0x00: 0x0A05 (LDL), 0x0801 (MOV), 0x7800 (HLT), RUN=1.
  - EX_EN pulses every 4 cycles.
  - OP_CODE sequence 1,1,F.
  - OP_DATA 0x05 on the first instruction.
  - HALTED=1 after the third EX_EN, INSTR_CNT=3.
  - ROM_REQ stays 0 afterwards.
- ROM ack delayed 3 cycles: ROM_ADDR stable and ROM_REQ high for 4 cycles; instruction period 7 cycles.
- ROM never acks, TIMEOUT=16: ROM_REQ high 16 cycles, then FETCH_ERR=1 and ROM_REQ=0; ack exactly on the 16th cycle gives no error.
- Exec model jumps P_COUNT to 0x40 on EX_EN: the next ROM_ADDR=0x40.
- RUN deasserted during DECODE: EX_EN still pulses once, then IDLE with ROM_REQ=0; re-asserting RUN resumes at the current P_COUNT.
- RESET during FETCH and during HALT: next cycle all outputs are 0 and state is IDLE; FETCH_ERR, HALTED and INSTR_CNT are cleared.
